// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, standard tap masks and the
// feedback function used by both the generator and the checker LFSRs.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } prbs_chk_state_t;

    localparam logic [6:0]  PRBS7_TAPS  = 7'b1100000;
    localparam logic [14:0] PRBS15_TAPS = 15'b110000000000000;

    // Callers zero-extend their register and mask to 32 bits
    function automatic logic prbs_fb(input logic [31:0] lfsr, input logic [31:0] taps);
        return ^(lfsr & taps);
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR shared by the PRBS generator and checker; shifts left and
// inserts either its own feedback or an externally supplied bit.
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = PRBS7_TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load_bit,
    input  logic             use_load,
    output logic [WIDTH-1:0] state,
    output logic             fb
);

    assign fb = prbs_fb(32'(state), 32'(TAPS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
        end else if (en) begin
            state <= {state[WIDTH-2:0], (use_load ? load_bit : fb)};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the received stream, locks after a
// run of correct predictions, counts errors and drops lock on excessive error density.
// Optional feature macro: PRBS_CHK_BITCNT_EN builds the 32-bit bit_count register.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] TAPS        = PRBS7_TAPS,
    parameter int               LOCK_CNT    = 16,
    parameter int               WINDOW      = 128,
    parameter int               LOSS_THRESH = 8,
    parameter int               ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      bit_count
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WP_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WE_W    = $clog2(WINDOW + 1);

    prbs_chk_state_t    chk_state;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WP_W-1:0]    win_pos;
    logic [WE_W-1:0]    win_err;
    logic [WIDTH-1:0]   lfsr_q;
    logic               expected;
    logic               mismatch;
    logic               fill_zero;
    logic               win_wrap;
    logic [WE_W-1:0]    win_err_next;
    logic               lose_lock;

    // Seeded from the wire until locked, then free-runs so one bad bit costs one error
    prbs_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (data_valid),
        .load_bit (data_in),
        .use_load (chk_state != LOCKED),
        .state    (lfsr_q),
        .fb       (expected)
    );

    assign mismatch     = data_in ^ expected;
    assign fill_zero    = (((lfsr_q << 1) | WIDTH'(data_in)) == '0);
    assign win_wrap     = (win_pos == WP_W'(WINDOW - 1));
    assign win_err_next = win_wrap ? WE_W'(mismatch) : (win_err + WE_W'(mismatch));
    assign lose_lock    = mismatch && (win_err_next >= WE_W'(LOSS_THRESH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_state <= SEARCH;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
        end else begin
            error <= 1'b0;
            if (data_valid) begin
                case (chk_state)
                    SEARCH: begin
                        if (fill_cnt == FILL_W'(WIDTH - 1)) begin
                            fill_cnt <= '0;
                            if (!fill_zero) begin
                                chk_state <= VERIFY;
                                match_cnt <= '0;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (mismatch) begin
                            chk_state <= SEARCH;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            chk_state <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            win_pos   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                    LOCKED: begin
                        error <= mismatch;
                        if (lose_lock) begin
                            chk_state <= SEARCH;
                            locked    <= 1'b0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            win_pos   <= '0;
                            win_err   <= '0;
                        end else begin
                            win_pos <= win_wrap ? '0 : (win_pos + WP_W'(1));
                            win_err <= win_err_next;
                        end
                    end
                    default: begin
                        chk_state <= SEARCH;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clr_cnt) begin
            err_count <= '0;
        end else if (data_valid && (chk_state == LOCKED) && mismatch && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_count <= '0;
        end else if (clr_cnt) begin
            bit_count <= '0;
        end else if (data_valid && (chk_state == LOCKED)) begin
            bit_count <= bit_count + 32'd1;
        end
    end
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: acquisition, single and burst errors, loss and
// relock, all-zero stream, error-counter saturation/clear, valid gaps and async reset.
module tb_prbs_checker;

`ifdef PRBS_CHK_BITCNT_EN
    localparam bit BITCNT = 1'b1;
`else
    localparam bit BITCNT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        data_in;
    logic        data_valid;
    logic        clr_cnt;
    logic        locked_a, error_a, locked_b, error_b;
    logic [15:0] err_count_a;
    logic [3:0]  err_count_b;
    logic [31:0] bit_count_a, bit_count_b;
    logic [6:0]  gen;
    int          total;
    int          bad;

    prbs_checker dut_a (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clr_cnt    (clr_cnt),
        .locked     (locked_a),
        .error      (error_a),
        .err_count  (err_count_a),
        .bit_count  (bit_count_a)
    );

    prbs_checker #(
        .ERR_W       (4),
        .LOSS_THRESH (128)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clr_cnt    (clr_cnt),
        .locked     (locked_b),
        .error      (error_b),
        .err_count  (err_count_b),
        .bit_count  (bit_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent PRBS7 source, x^7+x^6+1
    task automatic gen_step(output logic b);
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
    endtask

    task automatic drive(input logic d, input logic v, input logic c);
        data_in    = d;
        data_valid = v;
        clr_cnt    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #4 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked_a); end
        total++; if (error_a !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error_a); end
        total++; if (err_count_a !== 16'd0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", err_count_a); end
        total++; if (bit_count_a !== 32'd0) begin bad++; $display("FAIL reset_bitcnt: got %0d want 0", bit_count_a); end
        #3 reset = 1'b1;
    endtask

    task automatic test_acquire();
        logic b;
        int   pulses;
        gen = 7'h7F;
        for (int i = 1; i <= 23; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
            if (i == 22) begin
                total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL acq_early: got %b want 0", locked_a); end
            end
            if (i == 23) begin
                total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL acq_lock: got %b want 1", locked_a); end
            end
        end
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
            if (error_a === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL acq_pulses: got %0d want 0", pulses); end
        total++; if (err_count_a !== 16'd0) begin bad++; $display("FAIL acq_errcnt: got %0d want 0", err_count_a); end
        total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL acq_hold: got %b want 1", locked_a); end
        total++; if (bit_count_a !== (BITCNT ? 32'd1000 : 32'd0)) begin bad++; $display("FAIL acq_bitcnt: got %0d want %0d", bit_count_a, BITCNT ? 1000 : 0); end
    endtask

    task automatic test_single_error();
        logic b;
        int   pulses;
        gen_step(b);
        drive(~b, 1'b1, 1'b0);
        total++; if (error_a !== 1'b1) begin bad++; $display("FAIL single_pulse: got %b want 1", error_a); end
        total++; if (err_count_a !== 16'd1) begin bad++; $display("FAIL single_errcnt: got %0d want 1", err_count_a); end
        total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL single_locked: got %b want 1", locked_a); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
            if (error_a === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL single_extra: got %0d want 0", pulses); end
        total++; if (err_count_a !== 16'd1) begin bad++; $display("FAIL single_hold: got %0d want 1", err_count_a); end
        total++; if (bit_count_a !== (BITCNT ? 32'd1021 : 32'd0)) begin bad++; $display("FAIL single_bitcnt: got %0d want %0d", bit_count_a, BITCNT ? 1021 : 0); end
    endtask

    task automatic test_clr_and_loss();
        logic b;
        gen_step(b);
        drive(b, 1'b1, 1'b1);
        total++; if (err_count_a !== 16'd0) begin bad++; $display("FAIL clr_errcnt: got %0d want 0", err_count_a); end
        total++; if (bit_count_a !== 32'd0) begin bad++; $display("FAIL clr_bitcnt: got %0d want 0", bit_count_a); end
        for (int i = 0; i < 139; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
        end
        total++; if (bit_count_a !== (BITCNT ? 32'd139 : 32'd0)) begin bad++; $display("FAIL clr_recount: got %0d want %0d", bit_count_a, BITCNT ? 139 : 0); end
        // Eight errors, alternating with clean bits, all inside one window
        for (int k = 1; k <= 8; k++) begin
            gen_step(b);
            drive(~b, 1'b1, 1'b0);
            if (k == 7) begin
                total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL loss_early: got %b want 1", locked_a); end
            end
            if (k < 8) begin
                gen_step(b);
                drive(b, 1'b1, 1'b0);
            end
        end
        total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL loss_drop: got %b want 0", locked_a); end
        total++; if (error_a !== 1'b1) begin bad++; $display("FAIL loss_pulse: got %b want 1", error_a); end
        total++; if (err_count_a !== 16'd8) begin bad++; $display("FAIL loss_errcnt: got %0d want 8", err_count_a); end
        total++; if (bit_count_a !== (BITCNT ? 32'd154 : 32'd0)) begin bad++; $display("FAIL loss_bitcnt: got %0d want %0d", bit_count_a, BITCNT ? 154 : 0); end
        for (int i = 1; i <= 23; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
            if (i == 22) begin
                total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", locked_a); end
            end
            if (i == 23) begin
                total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", locked_a); end
            end
        end
        total++; if (err_count_a !== 16'd8) begin bad++; $display("FAIL relock_errcnt: got %0d want 8", err_count_a); end
        total++; if (bit_count_a !== (BITCNT ? 32'd154 : 32'd0)) begin bad++; $display("FAIL relock_bitcnt: got %0d want %0d", bit_count_a, BITCNT ? 154 : 0); end
    endtask

    task automatic test_zero_stream();
        int pulses;
        int lock_seen;
        pulse_reset();
        pulses    = 0;
        lock_seen = 0;
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (error_a === 1'b1) pulses++;
            if (locked_a === 1'b1) lock_seen++;
        end
        total++; if (lock_seen !== 0) begin bad++; $display("FAIL zero_locked: got %0d locked cycles want 0", lock_seen); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL zero_pulses: got %0d want 0", pulses); end
        total++; if (err_count_a !== 16'd0) begin bad++; $display("FAIL zero_errcnt: got %0d want 0", err_count_a); end
    endtask

    task automatic test_saturation();
        logic b;
        pulse_reset();
        gen = 7'h7F;
        for (int i = 0; i < 23; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
        end
        total++; if (locked_b !== 1'b1) begin bad++; $display("FAIL sat_lock: got %b want 1", locked_b); end
        for (int i = 1; i <= 20; i++) begin
            gen_step(b);
            drive(~b, 1'b1, 1'b0);
            if (i == 14) begin
                total++; if (err_count_b !== 4'd14) begin bad++; $display("FAIL sat_count14: got %0d want 14", err_count_b); end
            end
        end
        total++; if (err_count_b !== 4'd15) begin bad++; $display("FAIL sat_value: got %0d want 15", err_count_b); end
        total++; if (locked_b !== 1'b1) begin bad++; $display("FAIL sat_locked: got %b want 1", locked_b); end
        gen_step(b);
        drive(~b, 1'b1, 1'b1);
        total++; if (err_count_b !== 4'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", err_count_b); end
        total++; if (error_b !== 1'b1) begin bad++; $display("FAIL sat_clr_pulse: got %b want 1", error_b); end
        gen_step(b);
        drive(~b, 1'b1, 1'b0);
        total++; if (err_count_b !== 4'd1) begin bad++; $display("FAIL sat_after_clr: got %0d want 1", err_count_b); end
    endtask

    task automatic test_valid_gaps();
        logic b;
        int   pulses;
        pulse_reset();
        gen    = 7'h7F;
        pulses = 0;
        for (int i = 1; i <= 23; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
            if (error_a === 1'b1) pulses++;
            if (i == 22) begin
                total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL gap_early: got %b want 0", locked_a); end
            end
            if (i == 23) begin
                total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL gap_lock: got %b want 1", locked_a); end
            end
            drive(~b, 1'b0, 1'b0);
            if (error_a === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL gap_pulses: got %0d want 0", pulses); end
        gen_step(b);
        drive(~b, 1'b1, 1'b0);
        total++; if (err_count_a !== 16'd1) begin bad++; $display("FAIL gap_errcnt: got %0d want 1", err_count_a); end
        // Reset lands between clock edges; outputs must clear without one
        #2 reset = 1'b0;
        #1;
        total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL async_locked: got %b want 0", locked_a); end
        total++; if (error_a !== 1'b0) begin bad++; $display("FAIL async_error: got %b want 0", error_a); end
        total++; if (err_count_a !== 16'd0) begin bad++; $display("FAIL async_errcnt: got %0d want 0", err_count_a); end
        #3 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
            drive(~b, 1'b0, 1'b0);
        end
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            gen_step(b);
            drive(b, 1'b1, 1'b0);
            if (i == 22) begin
                total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL verify_reset_early: got %b want 0", locked_a); end
            end
            if (i == 23) begin
                total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL verify_reset_lock: got %b want 1", locked_a); end
            end
            drive(~b, 1'b0, 1'b0);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        data_in    = 1'b0;
        data_valid = 1'b0;
        clr_cnt    = 1'b0;
        gen        = 7'h7F;
        $display("[TB] prbs_checker bench start");
        test_reset();
        test_acquire();
        test_single_error();
        test_clr_and_loss();
        test_zero_stream();
        test_saturation();
        test_valid_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
